// File: rtl/tone_wave_gen.sv
`default_nettype none
// ============================================================================
// Module      : tone_wave_gen
// Description : Converts per-channel tone frequencies (Hz) into 50%-duty square
//               waves and signed 16-bit PCM samples. One iterative restoring
//               divider is shared by both channels. It turns each newly seen
//               audible tone into a half-period cycle count
//               (CLK_HZ / (2*tone)). Silent tones (0 Hz or above
//               MAX_AUDIBLE_HZ) bypass the divider and give a zero sample.
// Ports       : clk          system clock
//               rst          synchronous reset, active-high
//               toneL/toneR  tone per channel in Hz (32 bit)
//               volume       amplitude step 0..7 (0 = silent)
//               mute         force both samples to zero
//               sq_left/right     square waves
//               audio_left/right  signed 16-bit samples
//               busy         divider is computing a half-period
// Revision    : 1.0  initial release
// ============================================================================
module tone_wave_gen #(
  parameter int unsigned CLK_HZ         = 100_000_000,
  parameter int unsigned MAX_AUDIBLE_HZ = 20_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] toneL,
  input  logic [31:0] toneR,
  input  logic [2:0]  volume,
  input  logic        mute,
  output logic        sq_left,
  output logic        sq_right,
  output logic [15:0] audio_left,
  output logic [15:0] audio_right,
  output logic        busy
);

  localparam logic [1:0]  S_IDLE   = 2'd0;
  localparam logic [1:0]  S_DIV    = 2'd1;
  localparam logic [1:0]  S_STORE  = 2'd2;
  localparam logic [31:0] DIVIDEND = CLK_HZ;
  localparam logic [31:0] MAX_AUD  = MAX_AUDIBLE_HZ;

  logic [1:0]  state, state_nx;

  // Index 0 = left, index 1 = right
  logic [31:0] tq    [2];   // registered tone inputs
  logic [31:0] com   [2];   // tone whose half-period is currently in use
  logic [31:0] lim   [2];   // half-period in cycles, 0 = silent
  logic [31:0] cnt   [2];
  logic [15:0] audio [2];
  logic [1:0]  sq;

  logic [31:0] t_lat;       // tone being divided
  logic        sel;         // channel being divided, 1 = right
  logic [4:0]  div_cnt;
  logic [33:0] rem;
  logic [31:0] quo;         // holds the dividend, then shifts in quotient bits

  logic        pick_l, pick_r, want, pick_sil;
  logic [31:0] pick_tone;
  logic [1:0]  commit;
  logic [31:0] commit_lim, commit_tone;

  logic [33:0] rem_sh, divisor;
  logic        ge;
  logic [15:0] amp;

  // Left channel has priority whenever both differ from their committed tone.
  assign pick_l    = (tq[0] != com[0]);
  assign pick_r    = (tq[1] != com[1]);
  assign want      = pick_l | pick_r;
  assign pick_tone = pick_l ? tq[0] : tq[1];
  assign pick_sil  = (pick_tone == 32'd0) || (pick_tone > MAX_AUD);

  // One restoring-division step: shift in the next dividend bit, subtract if possible
  assign rem_sh  = {rem[32:0], quo[31]};
  assign divisor = {1'b0, t_lat, 1'b0};
  assign ge      = (rem_sh >= divisor);

  assign amp = {1'b0, volume, 12'h000};

  // ---------------- state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  // ---------------- next-state logic ----------------
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (want && !pick_sil) state_nx = S_DIV;
      S_DIV:   if (div_cnt == 5'd31)  state_nx = S_STORE;
      S_STORE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // ---------------- output / commit logic ----------------
  always_comb begin
    busy        = 1'b0;
    commit      = 2'b00;
    commit_lim  = 32'd0;
    commit_tone = 32'd0;
    case (state)
      S_IDLE: begin
        // Silent tones commit directly, no division needed
        if (want && pick_sil) begin
          commit      = pick_l ? 2'b01 : 2'b10;
          commit_tone = pick_tone;
        end
      end
      S_DIV: busy = 1'b1;
      S_STORE: begin
        commit      = sel ? 2'b10 : 2'b01;
        commit_lim  = quo;
        commit_tone = t_lat;
      end
      default: ;
    endcase
  end

  // ---------------- input registers and divider datapath ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      tq[0]   <= 32'd0;
      tq[1]   <= 32'd0;
      t_lat   <= 32'd0;
      sel     <= 1'b0;
      div_cnt <= 5'd0;
      rem     <= 34'd0;
      quo     <= 32'd0;
    end else begin
      tq[0] <= toneL;
      tq[1] <= toneR;
      if (state == S_IDLE) begin
        if (want && !pick_sil) begin
          t_lat   <= pick_tone;
          sel     <= !pick_l;
          div_cnt <= 5'd0;
          rem     <= 34'd0;
          quo     <= DIVIDEND;
        end
      end else if (state == S_DIV) begin
        rem     <= ge ? (rem_sh - divisor) : rem_sh;
        quo     <= {quo[30:0], ge};
        div_cnt <= div_cnt + 5'd1;
      end
    end
  end

  // ---------------- per-channel half-period counters and samples ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 2; i++) begin
        com[i]   <= 32'd0;
        lim[i]   <= 32'd0;
        cnt[i]   <= 32'd0;
        audio[i] <= 16'd0;
      end
      sq <= 2'b00;
    end else begin
      for (int i = 0; i < 2; i++) begin
        // A fresh commit restarts the count but keeps the current wave level
        if (commit[i]) begin
          com[i] <= commit_tone;
          lim[i] <= commit_lim;
          cnt[i] <= 32'd0;
        end else if (lim[i] == 32'd0) begin
          cnt[i] <= 32'd0;
          sq[i]  <= 1'b0;
        end else if (cnt[i] == lim[i] - 32'd1) begin
          cnt[i] <= 32'd0;
          sq[i]  <= ~sq[i];
        end else begin
          cnt[i] <= cnt[i] + 32'd1;
        end

        if (mute || (volume == 3'd0) || (lim[i] == 32'd0))
          audio[i] <= 16'd0;
        else
          audio[i] <= sq[i] ? amp : (~amp + 16'd1);
      end
    end
  end

  assign sq_left     = sq[0];
  assign sq_right    = sq[1];
  assign audio_left  = audio[0];
  assign audio_right = audio[1];

endmodule
`default_nettype wire
